// File: rtl/inst_loader.sv
// inst_loader: streams W-bit instruction words from a valid/ready source into
// instruction memory at addresses 0..len-1. The core is kept in reset (CoreHold)
// until the last word is written. Each Start pulse begins one load session.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A:0]   Length,
    input  logic [W-1:0] InData,
    input  logic         InValid,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         CoreHold,
    output logic         Done,
    output logic [W-1:0] Checksum
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};
    localparam logic [A:0] ONE     = {{A{1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [A:0]   len, count, len_in, count_inc;
    logic         xfer, last, start_ok;

    // Requests longer than the memory are clamped to its depth.
    assign len_in    = (Length > MAX_LEN) ? MAX_LEN : Length;
    assign count_inc = count + ONE;
    assign xfer      = InValid && InReady;
    assign last      = xfer && (count_inc == len);
    // A Start arriving mid-load is dropped so the session cannot be re-sampled.
    assign start_ok  = Start && (state != S_LOAD);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_n  = state;
        InReady  = 1'b0;
        CoreHold = 1'b1;
        Done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_n = (len_in == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                InReady = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                CoreHold = 1'b0;
                Done     = 1'b1;
                if (Start) state_n = (len_in == '0) ? S_DONE : S_LOAD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Session bookkeeping and the registered write port (one cycle after each transfer).
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            len      <= '0;
            count    <= '0;
            WrEn     <= 1'b0;
            WrAddr   <= '0;
            WrData   <= '0;
            Checksum <= '0;
        end else begin
            WrEn <= xfer;
            if (start_ok) begin
                len      <= len_in;
                count    <= '0;
                Checksum <= '0;
            end else if (xfer) begin
                WrAddr   <= count[A-1:0];
                WrData   <= InData;
                Checksum <= Checksum ^ InData;
                count    <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: randomized and directed load sessions
// compared against a queue-based model of the expected memory writes.
module tb_inst_loader;
    localparam int A = 10;
    localparam int W = 9;
    localparam int L = A + 1;

    logic         Clk = 1'b0, Reset = 1'b0, Start = 1'b0, InValid = 1'b0;
    logic [A:0]   Length = '0;
    logic [W-1:0] InData = '0;
    logic         InReady, WrEn, CoreHold, Done;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData, Checksum;

    int checks = 0, failures = 0, ncyc = 0, timeouts = 0;

    // observed writes and transfers, logged away from the clock edge
    logic [A-1:0] wa_q[$];
    logic [W-1:0] wd_q[$];
    int           wc_q[$];
    logic         wh_q[$];
    int           xc_q[$];

    inst_loader #(.A(A), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Length(Length),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CoreHold(CoreHold), .Done(Done), .Checksum(Checksum)
    );

    initial forever #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            wa_q.push_back(WrAddr); wd_q.push_back(WrData);
            wc_q.push_back(ncyc);   wh_q.push_back(CoreHold);
        end
        if (Reset && InValid && InReady === 1'b1) xc_q.push_back(ncyc);
        ncyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); wh_q.delete(); xc_q.delete();
    endtask

    task automatic do_start(input int len);
        Length = L'(len); Start = 1'b1;
        tick();
        Start = 1'b0; Length = L'($urandom);
    endtask

    // Offer one word after 'gap' idle cycles; optionally pulse Start during the gap.
    task automatic push_word(input logic [W-1:0] d, input int gap, input bit mid_start);
        for (int g = 0; g < gap; g++) begin
            InValid = 1'b0; InData = W'($urandom);
            Start = mid_start && (g == 0); Length = L'($urandom_range(1, 2047));
            tick();
            Start = 1'b0;
        end
        InValid = 1'b1; InData = d;
        for (int t = 0; t < 20; t++) begin
            @(negedge Clk);
            if (InReady === 1'b1) begin
                @(posedge Clk); #1;
                InValid = 1'b0; InData = W'($urandom);
                return;
            end
        end
        timeouts++;
        InValid = 1'b0;
        tick();
    endtask

    task automatic send_session(input logic [W-1:0] words[$], input int maxgap, input bit mid);
        foreach (words[i])
            push_word(words[i], $urandom_range(0, maxgap), mid && ($urandom_range(0, 1) == 1));
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0;
        repeat (2) tick();
        checks++; if (CoreHold !== 1'b1) begin failures++; $display("FAIL reset_corehold got=%b want=1", CoreHold); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", Done); end
        checks++; if (WrEn !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b want=0", WrEn); end
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b want=0", InReady); end
        checks++; if (Checksum !== '0) begin failures++; $display("FAIL reset_checksum got=%h want=0", Checksum); end
        checks++; if (WrAddr !== '0 || WrData !== '0) begin failures++; $display("FAIL reset_wrport got=%h:%h want=0:0", WrAddr, WrData); end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] cs;
        exp_q = '{9'h1E0, 9'h041, 9'h1FF, 9'h000};
        cs = '0; foreach (exp_q[i]) cs ^= exp_q[i];
        clear_logs();
        do_start(4);
        send_session(exp_q, 0, 1'b0);
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL basic_nwrites got=%0d want=4", wa_q.size()); end
        foreach (exp_q[i]) if (i < wa_q.size()) begin
            checks++;
            if (wa_q[i] !== A'(i) || wd_q[i] !== exp_q[i] || i >= xc_q.size() || wc_q[i] != xc_q[i] + 1) begin
                failures++; $display("FAIL basic_write%0d got=%h:%h want=%h:%h", i, wa_q[i], wd_q[i], A'(i), exp_q[i]);
            end
        end
        if (wh_q.size() == 4) begin
            checks++; if (wh_q[3] !== 1'b0 || wh_q[2] !== 1'b1) begin failures++; $display("FAIL basic_hold_edge got=%b%b want=10", wh_q[2], wh_q[3]); end
        end
        checks++; if (Checksum !== cs) begin failures++; $display("FAIL basic_checksum got=%h want=%h", Checksum, cs); end
        checks++; if (Done !== 1'b1 || CoreHold !== 1'b0 || InReady !== 1'b0) begin failures++; $display("FAIL basic_done got=%b%b%b want=100", Done, CoreHold, InReady); end
    endtask

    task automatic test_gaps();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] cs;
        for (int i = 0; i < 3; i++) exp_q.push_back(W'($urandom));
        cs = exp_q[0] ^ exp_q[1] ^ exp_q[2];
        clear_logs();
        do_start(3);
        push_word(exp_q[0], 0, 1'b0);
        push_word(exp_q[1], 2, 1'b1);
        push_word(exp_q[2], 5, 1'b1);
        repeat (3) tick();
        checks++; if (wa_q.size() != 3) begin failures++; $display("FAIL gaps_nwrites got=%0d want=3", wa_q.size()); end
        foreach (exp_q[i]) if (i < wa_q.size()) begin
            checks++;
            if (wa_q[i] !== A'(i) || wd_q[i] !== exp_q[i] || i >= xc_q.size() || wc_q[i] != xc_q[i] + 1) begin
                failures++; $display("FAIL gaps_write%0d got=%h:%h want=%h:%h", i, wa_q[i], wd_q[i], A'(i), exp_q[i]);
            end
        end
        checks++; if (Checksum !== cs || Done !== 1'b1) begin failures++; $display("FAIL gaps_end got=%h/%b want=%h/1", Checksum, Done, cs); end
    endtask

    task automatic test_len_bounds();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] cs;
        int bad;
        clear_logs();
        do_start(0);
        checks++; if (Done !== 1'b1 || CoreHold !== 1'b0) begin failures++; $display("FAIL zero_done got=%b/%b want=1/0", Done, CoreHold); end
        checks++; if (Checksum !== '0) begin failures++; $display("FAIL zero_checksum got=%h want=0", Checksum); end
        InValid = 1'b1; repeat (3) tick(); InValid = 1'b0;
        checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL zero_writes got=%0d want=0", wa_q.size()); end
        cs = '0;
        for (int i = 0; i < 1024; i++) begin exp_q.push_back(W'($urandom)); cs ^= exp_q[i]; end
        clear_logs();
        do_start(2047);
        send_session(exp_q, 0, 1'b0);
        checks++; if (wa_q.size() != 1024) begin failures++; $display("FAIL clamp_nwrites got=%0d want=1024", wa_q.size()); end
        bad = 0;
        foreach (exp_q[i]) if (i < wa_q.size())
            if (wa_q[i] !== A'(i) || wd_q[i] !== exp_q[i] || i >= xc_q.size() || wc_q[i] != xc_q[i] + 1) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL clamp_writes got=%0d bad want=0 bad", bad); end
        if (wa_q.size() > 0) begin
            checks++; if (wa_q[wa_q.size()-1] !== A'(1023)) begin failures++; $display("FAIL clamp_last_addr got=%0d want=1023", wa_q[wa_q.size()-1]); end
        end
        checks++; if (Checksum !== cs || Done !== 1'b1) begin failures++; $display("FAIL clamp_end got=%h/%b want=%h/1", Checksum, Done, cs); end
        clear_logs();
        InValid = 1'b1; repeat (4) tick(); InValid = 1'b0;
        checks++; if (wa_q.size() != 0 || InReady !== 1'b0) begin failures++; $display("FAIL clamp_nowrap got=%0d/%b want=0/0", wa_q.size(), InReady); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] exp_q[$];
        do_start(5);
        push_word(W'($urandom), 0, 1'b0);
        push_word(W'($urandom), 0, 1'b0);
        tick();
        clear_logs();
        Reset = 1'b0; InValid = 1'b1; InData = W'($urandom);
        repeat (2) tick();
        Reset = 1'b1;
        repeat (2) tick();
        InValid = 1'b0;
        checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL abort_writes got=%0d want=0", wa_q.size()); end
        checks++; if (CoreHold !== 1'b1 || Done !== 1'b0 || InReady !== 1'b0) begin failures++; $display("FAIL abort_state got=%b%b%b want=100", CoreHold, Done, InReady); end
        exp_q = '{W'($urandom), W'($urandom)};
        clear_logs();
        do_start(2);
        send_session(exp_q, 1, 1'b0);
        checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL reload_nwrites got=%0d want=2", wa_q.size()); end
        foreach (exp_q[i]) if (i < wa_q.size()) begin
            checks++;
            if (wa_q[i] !== A'(i) || wd_q[i] !== exp_q[i]) begin failures++; $display("FAIL reload_write%0d got=%h:%h want=%h:%h", i, wa_q[i], wd_q[i], A'(i), exp_q[i]); end
        end
        checks++; if (Checksum !== (exp_q[0] ^ exp_q[1])) begin failures++; $display("FAIL reload_checksum got=%h want=%h", Checksum, exp_q[0] ^ exp_q[1]); end
    endtask

    task automatic test_second_session();
        logic [W-1:0] exp_q[$];
        exp_q = '{9'h0AA};
        clear_logs();
        do_start(1);
        checks++; if (CoreHold !== 1'b1 || Done !== 1'b0 || InReady !== 1'b1) begin failures++; $display("FAIL second_loading got=%b%b%b want=101", CoreHold, Done, InReady); end
        send_session(exp_q, 2, 1'b0);
        checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL second_nwrites got=%0d want=1", wa_q.size()); end
        else begin
            checks++; if (wa_q[0] !== '0 || wd_q[0] !== 9'h0AA) begin failures++; $display("FAIL second_write got=%h:%h want=0:0aa", wa_q[0], wd_q[0]); end
        end
        checks++; if (Checksum !== 9'h0AA || Done !== 1'b1 || CoreHold !== 1'b0) begin failures++; $display("FAIL second_end got=%h/%b/%b want=0aa/1/0", Checksum, Done, CoreHold); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            logic [W-1:0] exp_q[$];
            logic [W-1:0] cs;
            int n;
            n = $urandom_range(1, 12);
            cs = '0;
            for (int i = 0; i < n; i++) begin exp_q.push_back(W'($urandom)); cs ^= exp_q[i]; end
            clear_logs();
            do_start(n);
            send_session(exp_q, 3, 1'b1);
            repeat (2) tick();
            checks++; if (wa_q.size() != n) begin failures++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", s, wa_q.size(), n); end
            foreach (exp_q[i]) if (i < wa_q.size()) begin
                checks++;
                if (wa_q[i] !== A'(i) || wd_q[i] !== exp_q[i] || i >= xc_q.size() || wc_q[i] != xc_q[i] + 1) begin
                    failures++; $display("FAIL rand%0d_write%0d got=%h:%h want=%h:%h", s, i, wa_q[i], wd_q[i], A'(i), exp_q[i]);
                end
            end
            checks++; if (Checksum !== cs || Done !== 1'b1 || CoreHold !== 1'b0) begin failures++; $display("FAIL rand%0d_end got=%h/%b/%b want=%h/1/0", s, Checksum, Done, CoreHold, cs); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_bounds();
        test_reset_abort();
        test_second_session();
        test_random();
        checks++; if (timeouts != 0) begin failures++; $display("FAIL handshake_timeouts got=%0d want=0", timeouts); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
